// File: rtl/vote_window_ctrl_if.sv
// Bundles the start/vote/result signals of vote_window_ctrl.
// master: the voter side plus the result consumer (drives start and votes).
// slave : the controller itself.
interface vote_window_ctrl_if;
  logic       start;
  logic [4:0] vote_valid;
  logic [4:0] vote_val;
  logic [4:0] vote_ack;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] yes_count;
  logic       timeout;

  modport master (
    output start, vote_valid, vote_val,
    input  vote_ack, busy, done, pass, yes_count, timeout
  );

  modport slave (
    input  start, vote_valid, vote_val,
    output vote_ack, busy, done, pass, yes_count, timeout
  );
endinterface

// File: rtl/vote_window_ctrl.sv
// vote_window_ctrl: opens a bounded voting window, latches at most one vote
// per voter, closes on full set or timer expiry, and evaluates the
// exactly-three-yes rule. Results hold until the next accepted start.
// Optional feature macro: VOTE_ABSTAIN_EN -- when defined, a timeout closure
// still yields pass = (yes_count == 3); when undefined, a timeout forces pass=0.
module vote_window_ctrl #(
  parameter int WINDOW = 16,
  parameter int WIN_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  vote_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [WIN_W-1:0] TIMER_LAST = WIN_W'(WINDOW - 1);
  localparam logic [4:0]       ALL_VOTED  = 5'b11111;

  state_t           state_q, state_d;
  logic [4:0]       mask_q, mask_d;       // voters already received
  logic [4:0]       votes_q, votes_d;     // latched vote values
  logic [WIN_W-1:0] timer_q, timer_d;
  logic             tmo_close_q, tmo_close_d; // window closed by the timer
  logic [4:0]       ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [4:0]       accept;
  logic [4:0]       yes_vec;
  logic [2:0]       yes_sum;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    votes_d     = votes_q;
    timer_d     = timer_q;
    tmo_close_d = tmo_close_q;
    ack_d       = 5'b00000;
    done_d      = 1'b0;
    pass_d      = pass_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    accept      = 5'b00000;
    yes_vec     = votes_q & mask_q;
    yes_sum     = 3'd0;

    for (int i = 0; i < 5; i++) begin
      yes_sum = yes_sum + 3'(yes_vec[i]);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = COLLECT;
          mask_d      = 5'b00000;
          votes_d     = 5'b00000;
          timer_d     = '0;
          tmo_close_d = 1'b0;
          pass_d      = 1'b0;
          cnt_d       = 3'd0;
          timeout_d   = 1'b0;
        end
      end

      COLLECT: begin
        // Only first votes count; repeats from a received voter are dropped.
        accept = bus.vote_valid & ~mask_q;
        for (int i = 0; i < 5; i++) begin
          if (accept[i]) votes_d[i] = bus.vote_val[i];
        end
        mask_d  = mask_q | accept;
        ack_d   = accept;
        timer_d = timer_q + 1'b1;
        // A complete set closing on the last timer cycle is not a timeout.
        if (mask_d == ALL_VOTED) begin
          state_d     = EVAL;
          tmo_close_d = 1'b0;
        end else if (timer_q == TIMER_LAST) begin
          state_d     = EVAL;
          tmo_close_d = 1'b1;
        end
      end

      EVAL: begin
        cnt_d     = yes_sum;
        timeout_d = tmo_close_q;
`ifdef VOTE_ABSTAIN_EN
        pass_d    = (yes_sum == 3'd3);
`else
        pass_d    = (yes_sum == 3'd3) && !tmo_close_q;
`endif
        done_d    = 1'b1;
        state_d   = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= 5'b00000;
      votes_q     <= 5'b00000;
      timer_q     <= '0;
      tmo_close_q <= 1'b0;
      ack_q       <= 5'b00000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      cnt_q       <= 3'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      votes_q     <= votes_d;
      timer_q     <= timer_d;
      tmo_close_q <= tmo_close_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.vote_ack  = ack_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.yes_count = cnt_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_vote_window_ctrl.sv
// Directed bench for vote_window_ctrl with a result scoreboard.
// Runs with WINDOW=4 so timer closures are short.
module tb_vote_window_ctrl;

  localparam int WIN = 4;

`ifdef VOTE_ABSTAIN_EN
  localparam logic TMO_PASS = 1'b1;
`else
  localparam logic TMO_PASS = 1'b0;
`endif

  typedef struct {
    logic       pass;
    logic [2:0] cnt;
    logic       tmo;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   dones;
  int   pushes;
  exp_t sb[$];

  vote_window_ctrl_if vif ();

  vote_window_ctrl #(.WINDOW(WIN), .WIN_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic p, input logic [2:0] c, input logic t);
    exp_t e;
    e.pass = p;
    e.cnt  = c;
    e.tmo  = t;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic clear_votes();
    vif.vote_valid = 5'b00000;
    vif.vote_val   = 5'b00000;
  endtask

  // Pulse start for one cycle from IDLE; returns in cycle t+1.
  task automatic do_start();
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
  endtask

  // All five voters in the first COLLECT cycle.
  task automatic full_vote(input logic [4:0] val, input logic ep, input logic [2:0] ec);
    do_start();
    chk("busy_after_start", {7'd0, vif.busy}, 8'd1);
    chk("pass_cleared", {7'd0, vif.pass}, 8'd0);
    chk("cnt_cleared", {5'd0, vif.yes_count}, 8'd0);
    vif.vote_valid = 5'b11111;
    vif.vote_val   = val;
    push_exp(ep, ec, 1'b0);
    tick();
    chk("ack_full", {3'd0, vif.vote_ack}, 8'h1f);
    chk("done_early", {7'd0, vif.done}, 8'd0);
    clear_votes();
    tick();
    chk("done_t3", {7'd0, vif.done}, 8'd1);
    chk("busy_in_done", {7'd0, vif.busy}, 8'd1);
    tick();
    chk("busy_t4", {7'd0, vif.busy}, 8'd0);
    chk("done_t4", {7'd0, vif.done}, 8'd0);
    chk("ack_quiet", {3'd0, vif.vote_ack}, 8'd0);
  endtask

  // Scoreboard consumer: every done pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (vif.done === 1'b1) begin
        dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", {7'd0, vif.done}, 8'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_pass", {7'd0, vif.pass}, {7'd0, e.pass});
          chk("sb_yes_count", {5'd0, vif.yes_count}, {5'd0, e.cnt});
          chk("sb_timeout", {7'd0, vif.timeout}, {7'd0, e.tmo});
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    dones  = 0;
    pushes = 0;
    rst_n  = 1'b0;
    vif.start = 1'b0;
    clear_votes();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_ack", {3'd0, vif.vote_ack}, 8'd0);
    chk("rst_busy", {7'd0, vif.busy}, 8'd0);
    chk("rst_done", {7'd0, vif.done}, 8'd0);
    chk("rst_pass", {7'd0, vif.pass}, 8'd0);
    chk("rst_cnt", {5'd0, vif.yes_count}, 8'd0);
    chk("rst_tmo", {7'd0, vif.timeout}, 8'd0);

    // Votes in IDLE are ignored
    vif.vote_valid = 5'b11111;
    vif.vote_val   = 5'b11111;
    tick();
    chk("idle_ack", {3'd0, vif.vote_ack}, 8'd0);
    chk("idle_busy", {7'd0, vif.busy}, 8'd0);
    tick();
    chk("idle_ack2", {3'd0, vif.vote_ack}, 8'd0);
    clear_votes();

    // Full-set evaluations
    full_vote(5'b00111, 1'b1, 3'd3);
    full_vote(5'b01111, 1'b0, 3'd4);
    full_vote(5'b00011, 1'b0, 3'd2);

    // Staggered votes, voter 3 repeats with a no, last vote at timer==WIN-1
    do_start();                       // t+1, timer 0
    vif.vote_valid = 5'b00101;
    vif.vote_val   = 5'b00101;
    tick();                           // t+2
    chk("stag_ack1", {3'd0, vif.vote_ack}, 8'h05);
    vif.vote_valid = 5'b00110;        // voter 2 yes, voter 3 repeat no
    vif.vote_val   = 5'b00010;
    tick();                           // t+3
    chk("stag_ack2_no_repeat", {3'd0, vif.vote_ack}, 8'h02);
    vif.vote_valid = 5'b01000;
    vif.vote_val   = 5'b00000;
    tick();                           // t+4, timer == WIN-1
    chk("stag_ack3", {3'd0, vif.vote_ack}, 8'h08);
    vif.vote_valid = 5'b10000;
    vif.vote_val   = 5'b00000;
    push_exp(1'b1, 3'd3, 1'b0);
    tick();                           // t+5, EVAL
    chk("stag_ack5", {3'd0, vif.vote_ack}, 8'h10);
    chk("stag_done_early", {7'd0, vif.done}, 8'd0);
    clear_votes();
    tick();                           // t+6
    chk("stag_done", {7'd0, vif.done}, 8'd1);
    tick();
    chk("stag_busy_off", {7'd0, vif.busy}, 8'd0);

    // Timer closure with voters 1-3 yes only
    do_start();                       // t+1
    vif.vote_valid = 5'b00111;
    vif.vote_val   = 5'b00111;
    push_exp(TMO_PASS, 3'd3, 1'b1);
    tick();                           // t+2
    chk("tmo_ack", {3'd0, vif.vote_ack}, 8'h07);
    clear_votes();
    tick();                           // t+3
    tick();                           // t+4
    chk("tmo_busy_collect", {7'd0, vif.busy}, 8'd1);
    tick();                           // t+5, EVAL
    chk("tmo_done_t5", {7'd0, vif.done}, 8'd0);
    tick();                           // t+6
    chk("tmo_done_t6", {7'd0, vif.done}, 8'd1);
    chk("tmo_flag", {7'd0, vif.timeout}, 8'd1);
    chk("tmo_pass", {7'd0, vif.pass}, {7'd0, TMO_PASS});
    tick();
    chk("tmo_busy_off", {7'd0, vif.busy}, 8'd0);
    chk("tmo_held", {7'd0, vif.timeout}, 8'd1);

    // Start held high while busy is ignored
    do_start();                       // t+1
    vif.start      = 1'b1;
    vif.vote_valid = 5'b00001;
    vif.vote_val   = 5'b00001;
    tick();                           // t+2
    chk("sb_ack_v1", {3'd0, vif.vote_ack}, 8'h01);
    vif.vote_valid = 5'b11110;
    vif.vote_val   = 5'b00110;
    push_exp(1'b1, 3'd3, 1'b0);
    tick();                           // t+3, EVAL
    clear_votes();
    tick();                           // t+4, DONE
    chk("busy_start_done", {7'd0, vif.done}, 8'd1);
    tick();                           // t+5
    vif.start = 1'b0;
    chk("busy_start_ignored", {7'd0, vif.busy}, 8'd0);
    tick();
    chk("busy_start_ignored2", {7'd0, vif.busy}, 8'd0);

    // Reset mid-COLLECT abandons the window
    do_start();
    vif.vote_valid = 5'b00011;
    vif.vote_val   = 5'b00011;
    tick();
    chk("mid_ack", {3'd0, vif.vote_ack}, 8'h03);
    clear_votes();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_ack", {3'd0, vif.vote_ack}, 8'd0);
    chk("mid_rst_busy", {7'd0, vif.busy}, 8'd0);
    chk("mid_rst_done", {7'd0, vif.done}, 8'd0);
    chk("mid_rst_pass", {7'd0, vif.pass}, 8'd0);
    chk("mid_rst_cnt", {5'd0, vif.yes_count}, 8'd0);
    chk("mid_rst_tmo", {7'd0, vif.timeout}, 8'd0);
    tick();
    tick();
    tick();
    tick();
    chk("mid_rst_no_done", {7'd0, vif.done}, 8'd0);
    chk("mid_rst_idle", {7'd0, vif.busy}, 8'd0);

    // Fresh window after reset
    full_vote(5'b11100, 1'b1, 3'd3);

    tick();
    chk("sb_empty", 8'(sb.size()), 8'd0);
    chk("done_count", 8'(dones), 8'(pushes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
